// File: rtl/mod_doubler_reg.sv
// Registered modular doubler: oData <= (2*iData) mod iQ, one-cycle latency,
// synchronous enable/clear, asynchronous active-low reset.

`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module mod_doubler_reg #(
    parameter int BITWIDTH = `BITWIDTH
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH:0]   dbl;
    logic                ge_q;
    logic [BITWIDTH-1:0] nxt;
    logic [BITWIDTH-1:0] odata_d;
    logic [BITWIDTH-1:0] odata_q;

    // The doubled operand keeps its carry bit so the compare against q is exact;
    // the subtraction itself only needs the low bits because r < 2^BITWIDTH.
    always_comb begin
        dbl  = {iData, 1'b0};
        ge_q = (dbl >= {1'b0, iQ});
        nxt  = ge_q ? (dbl[BITWIDTH-1:0] - iQ) : dbl[BITWIDTH-1:0];
    end

    // Clear wins over enable; with neither the register holds.
    always_comb begin
        odata_d = odata_q;
        if (iClr) begin
            odata_d = '0;
        end else if (iEn) begin
            odata_d = nxt;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create simulation/synthesis mismatches.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            odata_q <= '0;
        end else begin
            odata_q <= odata_d;
        end
    end

    assign oData = odata_q;

endmodule

// File: tb/tb_mod_doubler_reg.sv
// Self-checking bench for mod_doubler_reg: directed corner cases plus a
// randomized stream compared against an arithmetic reference model.

module tb_mod_doubler_reg;

    localparam int BW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clr;
    logic [BW-1:0] data;
    logic [BW-1:0] q;
    logic [BW-1:0] odata;

    logic [BW-1:0] exp_q;
    int            n_cmp;
    int            n_err;

    mod_doubler_reg #(.BITWIDTH(BW)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .iEn   (en),
        .iClr  (clr),
        .iData (data),
        .iQ    (q),
        .oData (odata)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [BW-1:0] ref_dbl(input int x, input int m);
        return BW'((2 * x) % m);
    endfunction

    // Drive one operand set mid-cycle, advance the model on the edge, check just after.
    task automatic step(input string tag, input logic e, input logic c,
                        input int x, input int m);
        @(negedge clk);
        en   = e;
        clr  = c;
        data = BW'(x);
        q    = BW'(m);
        @(posedge clk);
        if (c)      exp_q = '0;
        else if (e) exp_q = ref_dbl(x, m);
        #1;
        check(tag, odata, exp_q);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_q = '0;
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        data  = 8'd10;
        q     = 8'd23;

        // Reset holds output at zero across a clock edge.
        #11;
        check("reset_hold", odata, 8'd0);
        #4;
        rst_n = 1'b1;

        // Sweep q down with x fixed at 10: 20,20,20,0,1,2,...
        for (int m = 23; m >= 14; m--) begin
            step("sweep", 1'b1, 1'b0, 10, m);
        end

        // Width / boundary cases.
        step("ovf_200_251", 1'b1, 1'b0, 200, 251);
        step("ovf_249_250", 1'b1, 1'b0, 249, 250);
        step("zero_x",      1'b1, 1'b0, 0,   7);
        step("max_x",       1'b1, 1'b0, 254, 255);
        step("two_x_eq_q",  1'b1, 1'b0, 5,   10);
        step("x_qm1",       1'b1, 1'b0, 12,  13);

        // Enable hold.
        step("en_load", 1'b1, 1'b0, 10, 19);
        step("en_hold", 1'b0, 1'b0, 3,  5);
        step("en_hold", 1'b0, 1'b0, 3,  5);
        step("en_raise", 1'b1, 1'b0, 3, 5);

        // Clear priority over enable.
        step("clr_pre",  1'b1, 1'b0, 3, 7);
        step("clr_prio", 1'b1, 1'b1, 3, 7);
        step("clr_rel",  1'b1, 1'b0, 3, 7);

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        exp_q = '0;
        #1;
        check("async_rst", odata, 8'd0);
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 1'b0, 3, 7);
        step("post_rst_load", 1'b1, 1'b0, 3, 7);

        // Randomized back-to-back stream with occasional enable drop / clear.
        for (int i = 0; i < 1000; i++) begin
            int m;
            int x;
            logic e;
            logic c;
            m = int'($urandom_range(2, 255));
            x = int'($urandom_range(0, m - 1));
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 49) == 0);
            step("random", e, c, x, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
